// File: rtl/bp_mem_cmd_arbiter_2to1.sv
// Two-requester bp_mem command arbiter with in-order response steering via an ID FIFO.
// Define BP_MEM_ARB_FIXED_PRIO_EN to make req0 always win instead of round-robin.
module bp_mem_cmd_arbiter_2to1 #(
  parameter int mem_msg_width_p = 128,
  parameter int fifo_els_p      = 4,
  localparam int ptr_width_lp   = $clog2(fifo_els_p+1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [2*mem_msg_width_p-1:0] req_cmd_i,
  input  logic [1:0]                   req_cmd_v_i,
  output logic [1:0]                   req_cmd_ready_o,
  output logic [mem_msg_width_p-1:0]   req_resp_o,
  output logic [1:0]                   req_resp_v_o,
  input  logic [1:0]                   req_resp_yumi_i,
  output logic [mem_msg_width_p-1:0]   mem_cmd_o,
  output logic                         mem_cmd_v_o,
  input  logic                         mem_cmd_ready_i,
  input  logic [mem_msg_width_p-1:0]   mem_resp_i,
  input  logic                         mem_resp_v_i,
  output logic                         mem_resp_yumi_o,
  output logic [ptr_width_lp-1:0]      outstanding_o
);

  localparam int addr_width_lp = $clog2(fifo_els_p);

  logic                     active;
  logic [fifo_els_p-1:0]    id_mem;
  logic [addr_width_lp-1:0] wr_ptr;
  logic [addr_width_lp-1:0] rd_ptr;
  logic [ptr_width_lp-1:0]  count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     winner;
  logic                     grant_v;
  logic                     head;
  logic                     push;
  logic                     pop;
  logic                     resp_v;

  assign fifo_full  = (count == ptr_width_lp'(fifo_els_p));
  assign fifo_empty = (count == '0);

`ifdef BP_MEM_ARB_FIXED_PRIO_EN
  assign winner = ~req_cmd_v_i[0];
`else
  logic rr_ptr;
  assign winner = (&req_cmd_v_i) ? rr_ptr : req_cmd_v_i[1];
`endif

  // active stays low through reset and the cycle after, masking every handshake
  assign grant_v         = active & ~reset_i & (|req_cmd_v_i) & ~fifo_full;
  assign mem_cmd_v_o     = grant_v;
  assign mem_cmd_o       = !grant_v ? '0
                         : winner   ? req_cmd_i[mem_msg_width_p +: mem_msg_width_p]
                                    : req_cmd_i[0 +: mem_msg_width_p];
  assign req_cmd_ready_o = (grant_v & mem_cmd_ready_i) ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign push            = grant_v & mem_cmd_ready_i;

  assign head            = id_mem[rd_ptr];
  assign resp_v          = active & ~reset_i & mem_resp_v_i & ~fifo_empty;
  assign req_resp_v_o    = resp_v ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign req_resp_o      = mem_resp_i;
  assign pop             = resp_v & req_resp_yumi_i[head];
  assign mem_resp_yumi_o = pop;
  assign outstanding_o   = count;

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr] <= winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
      active <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + addr_width_lp'(1);
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
        rr_ptr <= ~winner;
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + addr_width_lp'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + ptr_width_lp'(1);
        2'b01:   count <= count - ptr_width_lp'(1);
        default: count <= count;
      endcase
    end
  end

  // A response with nothing outstanding cannot be steered anywhere
  always_ff @(posedge clk_i) begin
    if (!reset_i && active) begin
      assert (!(mem_resp_v_i && fifo_empty))
        else $error("bp_mem_cmd_arbiter_2to1: mem_resp_v_i with no outstanding command");
    end
  end

endmodule

// File: tb/tb_bp_mem_cmd_arbiter_2to1.sv
// Directed self-checking bench for bp_mem_cmd_arbiter_2to1.
// Expectations switch to req0-always-wins when BP_MEM_ARB_FIXED_PRIO_EN is defined.
module tb_bp_mem_cmd_arbiter_2to1;

  localparam int W = 128;

  logic           clk;
  logic           reset;
  logic [2*W-1:0] req_cmd;
  logic [1:0]     req_cmd_v;
  logic [1:0]     req_cmd_ready;
  logic [W-1:0]   req_resp;
  logic [1:0]     req_resp_v;
  logic [1:0]     req_resp_yumi;
  logic [W-1:0]   mem_cmd;
  logic           mem_cmd_v;
  logic           mem_cmd_ready;
  logic [W-1:0]   mem_resp;
  logic           mem_resp_v;
  logic           mem_resp_yumi;
  logic [2:0]     outstanding;

  int tests_run;
  int tests_failed;

  bp_mem_cmd_arbiter_2to1 #(.mem_msg_width_p(W), .fifo_els_p(4)) dut (
    .clk_i(clk),
    .reset_i(reset),
    .req_cmd_i(req_cmd),
    .req_cmd_v_i(req_cmd_v),
    .req_cmd_ready_o(req_cmd_ready),
    .req_resp_o(req_resp),
    .req_resp_v_o(req_resp_v),
    .req_resp_yumi_i(req_resp_yumi),
    .mem_cmd_o(mem_cmd),
    .mem_cmd_v_o(mem_cmd_v),
    .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_i(mem_resp),
    .mem_resp_v_i(mem_resp_v),
    .mem_resp_yumi_o(mem_resp_yumi),
    .outstanding_o(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [W-1:0] c0, input logic [W-1:0] c1,
                               input logic rdy, input logic rv, input logic [W-1:0] rdata,
                               input logic [1:0] yumi);
    req_cmd_v     = v;
    req_cmd       = {c1, c0};
    mem_cmd_ready = rdy;
    mem_resp_v    = rv;
    mem_resp      = rdata;
    req_resp_yumi = yumi;
  endtask

  task automatic applyReset;
    reset = 1'b1;
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00);
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  logic [1:0]   exp_win;
  logic [W-1:0] exp_cmd [4];
  logic [1:0]   exp_head [5];
  logic [W-1:0] exp_rel_cmd;
  int           a_idx;
  int           b_idx;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
    exp_cmd  = '{W'('hA0), W'('hA1), W'('hA2), W'('hA3)};
    exp_head = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    exp_rel_cmd = W'('hA6);
`else
    exp_cmd  = '{W'('hA0), W'('hB0), W'('hA1), W'('hB1)};
    exp_head = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    exp_rel_cmd = W'('hB5);
`endif

    // reset state, including the masked first cycle after reset
    reset = 1'b1;
    applyStimulus(2'b11, W'('h1), W'('h2), 1'b1, 1'b0, '0, 2'b00);
    tick;
    tick;
    checkOutput("rst_cmd_v", W'(mem_cmd_v), W'(0));
    checkOutput("rst_ready", W'(req_cmd_ready), W'(0));
    checkOutput("rst_outst", W'(outstanding), W'(0));
    reset = 1'b0;
    settle;
    checkOutput("post_rst_cmd_v", W'(mem_cmd_v), W'(0));
    checkOutput("post_rst_ready", W'(req_cmd_ready), W'(0));
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    tick;

    // single requester, back-to-back
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, W'('h10 + i), '0, 1'b1, 1'b0, '0, 2'b00);
      settle;
      checkOutput("t1_cmd_v", W'(mem_cmd_v), W'(1));
      checkOutput("t1_cmd", mem_cmd, W'('h10 + i));
      checkOutput("t1_ready", W'(req_cmd_ready), W'(2'b01));
      tick;
    end
    applyStimulus(2'b00, W'('h77), W'('h88), 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t1_nogrant_cmd", mem_cmd, W'(0));
    checkOutput("t1_nogrant_v", W'(mem_cmd_v), W'(0));
    checkOutput("t1_outst3", W'(outstanding), W'(3));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, W'('h50 + i), 2'b01);
      settle;
      checkOutput("t1_resp_v", W'(req_resp_v), W'(2'b01));
      checkOutput("t1_resp", req_resp, W'('h50 + i));
      checkOutput("t1_yumi", W'(mem_resp_yumi), W'(1));
      tick;
    end
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t1_outst0", W'(outstanding), W'(0));

    // contention, then FIFO full with simultaneous pop and request
    applyReset;
    a_idx = 0;
    b_idx = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, W'('hA0 + a_idx), W'('hB0 + b_idx), 1'b1, 1'b0, '0, 2'b00);
      settle;
      checkOutput("t2_cmd", mem_cmd, exp_cmd[i]);
      exp_win = (exp_cmd[i][7:4] == 4'hA) ? 2'b01 : 2'b10;
      checkOutput("t2_ready", W'(req_cmd_ready), W'(exp_win));
      tick;
      if (exp_win == 2'b01) a_idx++;
      else b_idx++;
    end
    applyStimulus(2'b11, W'('hC0), W'('hD0), 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t4_outst4", W'(outstanding), W'(4));
    checkOutput("t4_full_cmd_v", W'(mem_cmd_v), W'(0));
    checkOutput("t4_full_ready", W'(req_cmd_ready), W'(0));
    applyStimulus(2'b01, W'('hC0), '0, 1'b1, 1'b1, W'('h60), 2'b11);
    settle;
    checkOutput("t4_pop_cmd_v", W'(mem_cmd_v), W'(0));
    checkOutput("t4_pop_ready", W'(req_cmd_ready), W'(0));
    checkOutput("t4_pop_yumi", W'(mem_resp_yumi), W'(1));
    checkOutput("t4_pop_steer", W'(req_resp_v), W'(exp_head[0]));
    tick;
    applyStimulus(2'b01, W'('hC0), '0, 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t4_outst3", W'(outstanding), W'(3));
    checkOutput("t4_late_ready", W'(req_cmd_ready), W'(2'b01));
    checkOutput("t4_late_cmd", mem_cmd, W'('hC0));
    tick;
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t4_outst4b", W'(outstanding), W'(4));
    for (int i = 1; i < 5; i++) begin
      applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, W'('h60 + i), 2'b11);
      settle;
      checkOutput("t2_steer", W'(req_resp_v), W'(exp_head[i]));
      checkOutput("t2_yumi", W'(mem_resp_yumi), W'(1));
      tick;
    end
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t2_outst0", W'(outstanding), W'(0));

    // backpressure holds req0's command, then release
    applyReset;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, W'('hA5), W'('hB5), 1'b0, 1'b0, '0, 2'b00);
      settle;
      checkOutput("t3_hold_v", W'(mem_cmd_v), W'(1));
      checkOutput("t3_hold_cmd", mem_cmd, W'('hA5));
      checkOutput("t3_hold_ready", W'(req_cmd_ready), W'(0));
      tick;
    end
    applyStimulus(2'b11, W'('hA5), W'('hB5), 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t3_rel_ready", W'(req_cmd_ready), W'(2'b01));
    checkOutput("t3_rel_cmd", mem_cmd, W'('hA5));
    tick;
    applyStimulus(2'b11, W'('hA6), W'('hB5), 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t3_next_cmd", mem_cmd, exp_rel_cmd);
    tick;
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t3_outst2", W'(outstanding), W'(2));

    // response stall: yumi on the non-head requester is ignored
    applyReset;
    applyStimulus(2'b10, '0, W'('hE1), 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t5_ready", W'(req_cmd_ready), W'(2'b10));
    tick;
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, W'('h99), 2'b01);
    settle;
    checkOutput("t5_resp_v", W'(req_resp_v), W'(2'b10));
    checkOutput("t5_stall_yumi", W'(mem_resp_yumi), W'(0));
    tick;
    checkOutput("t5_outst1", W'(outstanding), W'(1));
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, W'('h99), 2'b10);
    settle;
    checkOutput("t5_yumi", W'(mem_resp_yumi), W'(1));
    checkOutput("t5_resp", req_resp, W'('h99));
    tick;
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t5_outst0", W'(outstanding), W'(0));

    // reset mid-flight with rr pointer favouring req1
    applyReset;
    applyStimulus(2'b10, '0, W'('hB7), 1'b1, 1'b0, '0, 2'b00);
    tick;
    applyStimulus(2'b01, W'('hA7), '0, 1'b1, 1'b0, '0, 2'b00);
    tick;
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    settle;
    checkOutput("t6_outst2", W'(outstanding), W'(2));
    reset = 1'b1;
    applyStimulus(2'b11, W'('hA7), W'('hB7), 1'b1, 1'b1, W'('h5), 2'b11);
    settle;
    checkOutput("t6_rst_cmd_v", W'(mem_cmd_v), W'(0));
    checkOutput("t6_rst_ready", W'(req_cmd_ready), W'(0));
    checkOutput("t6_rst_resp_v", W'(req_resp_v), W'(0));
    checkOutput("t6_rst_yumi", W'(mem_resp_yumi), W'(0));
    tick;
    reset = 1'b0;
    applyStimulus(2'b11, W'('hA7), W'('hB7), 1'b1, 1'b0, '0, 2'b11);
    settle;
    checkOutput("t6_outst0", W'(outstanding), W'(0));
    checkOutput("t6_post_cmd_v", W'(mem_cmd_v), W'(0));
    checkOutput("t6_post_ready", W'(req_cmd_ready), W'(0));
    tick;
    checkOutput("t6_win_v", W'(mem_cmd_v), W'(1));
    checkOutput("t6_win_cmd", mem_cmd, W'('hA7));
    checkOutput("t6_win_ready", W'(req_cmd_ready), W'(2'b01));
    tick;
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
